key_stepper: RTL and testbench

Converts debounced, active-low push-button levels into a saturating parameter value for run-time tuning of the hybrid controller, such as thresholds or phase offsets. It sits directly downstream of `debounce` and takes its `o_switch` bits as key inputs. A single tap steps the value once. Holding a key auto-repeats after a delay. Pressing both keys is ignored until both are released.

---
 rtl/key_stepper_pkg.sv | 14 +
 rtl/key_stepper_sat_step.sv | 42 ++++
 rtl/key_stepper.sv | 147 ++++++++++++++
 tb/tb_key_stepper.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/key_stepper_pkg.sv
// Shared state encodings and direction constants for the key stepper.
package key_stepper_pkg;

  typedef enum logic [1:0] {
    ST_LOCK   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/key_stepper_sat_step.sv
// Combinational saturating step: moves a value by STEP toward MAX or MIN
// without wrapping, and flags whether the result differs from the input.
module sat_step
  import key_stepper_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MIN   = 0,
  parameter int unsigned MAX   = 255,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] next_o,
  output logic             changed_o
);

  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_N  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] MIN_N  = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] STEP_N = WIDTH'(STEP);

  logic [WIDTH:0] valueX;
  logic [WIDTH:0] sumX;
  logic [WIDTH:0] floorX;

  // One extra bit keeps the overflow/underflow tests exact before saturating.
  always_comb begin
    valueX = {1'b0, value_i};
    sumX   = valueX + STEP_X;
    floorX = MIN_X + STEP_X;
    next_o = value_i;
    if (dir_i == DIR_UP) begin
      next_o = (sumX > MAX_X) ? MAX_N : sumX[WIDTH-1:0];
    end else begin
      next_o = (valueX < floorX) ? MIN_N : (value_i - STEP_N);
    end
    changed_o = (next_o != value_i);
  end

endmodule

// File: rtl/key_stepper.sv
// Turns two debounced active-low keys into a saturating tunable value with
// tap stepping, hold-to-repeat, and a both-keys lockout.
module key_stepper
  import key_stepper_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned MIN           = 0,
  parameter int unsigned MAX           = 255,
  parameter int unsigned INIT          = 128,
  parameter int unsigned STEP          = 1,
  parameter int unsigned HOLD_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_key_up,
  input  logic             i_key_down,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_value,
  output logic             o_changed,
  output logic             o_at_min,
  output logic             o_at_max
);

  if (!((MIN <= INIT) && (INIT <= MAX) && (64'(MAX) < (64'd1 << WIDTH)))) begin : g_bad_range
    $error("key_stepper: require MIN <= INIT <= MAX < 2**WIDTH");
  end
  if ((STEP < 1) || (HOLD_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_timing
    $error("key_stepper: STEP, HOLD_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam logic [WIDTH-1:0] INIT_N     = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] MIN_N      = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_N      = WIDTH'(MAX);
  localparam logic [31:0]      HOLD_LAST  = 32'(HOLD_DELAY - 1);
  localparam logic [31:0]      REPEAT_LAST = 32'(REPEAT_PERIOD - 1);

  state_e           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             changed_q, changed_d;
  logic             atMin_q, atMax_q;

  logic             upPressed, downPressed, activePressed, otherPressed;
  logic             doStep, stepDir;
  logic [WIDTH-1:0] stepValue;
  logic             stepChanged;

  assign upPressed   = ~i_key_up;
  assign downPressed = ~i_key_down;

  sat_step #(
    .WIDTH (WIDTH),
    .MIN   (MIN),
    .MAX   (MAX),
    .STEP  (STEP)
  ) u_sat_step (
    .value_i   (value_q),
    .dir_i     (stepDir),
    .next_o    (stepValue),
    .changed_o (stepChanged)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dir_d         = dir_q;
    doStep        = 1'b0;
    stepDir       = dir_q;
    activePressed = (dir_q == DIR_UP) ? upPressed : downPressed;
    otherPressed  = (dir_q == DIR_UP) ? downPressed : upPressed;

    unique case (state_q)
      ST_LOCK: begin
        if (!upPressed && !downPressed) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (upPressed && downPressed) begin
          state_d = ST_LOCK;
        end else if (upPressed || downPressed) begin
          doStep  = 1'b1;
          stepDir = upPressed ? DIR_UP : DIR_DOWN;
          dir_d   = stepDir;
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD, ST_REPEAT: begin
        if (!activePressed) begin
          state_d = ST_IDLE;
        end else if (otherPressed) begin
          state_d = ST_LOCK;
        end else if ((state_q == ST_HOLD) && (cnt_q == HOLD_LAST)) begin
          doStep  = 1'b1;
          state_d = ST_REPEAT;
          cnt_d   = '0;
        end else if ((state_q == ST_REPEAT) && (cnt_q == REPEAT_LAST)) begin
          doStep = 1'b1;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = ST_LOCK;
    endcase

    // Clear overrides any step and re-arms the lockout so a held key is ignored.
    value_d   = value_q;
    changed_d = 1'b0;
    if (i_clear) begin
      value_d   = INIT_N;
      changed_d = (value_q != INIT_N);
      state_d   = ST_LOCK;
      cnt_d     = '0;
    end else if (doStep) begin
      value_d   = stepValue;
      changed_d = stepChanged;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_LOCK;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      value_q   <= INIT_N;
      changed_q <= 1'b0;
      atMin_q   <= (INIT_N == MIN_N);
      atMax_q   <= (INIT_N == MAX_N);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      value_q   <= value_d;
      changed_q <= changed_d;
      atMin_q   <= (value_d == MIN_N);
      atMax_q   <= (value_d == MAX_N);
    end
  end

  assign o_value   = value_q;
  assign o_changed = changed_q;
  assign o_at_min  = atMin_q;
  assign o_at_max  = atMax_q;

endmodule

// File: tb/tb_key_stepper.sv
// Scoreboard bench for key_stepper: directed scenarios plus random key traffic
// checked against a hold-duration reference model.
module tb_key_stepper;

  localparam int WIDTH = 8;
  localparam int MIN   = 10;
  localparam int MAX   = 20;
  localparam int INIT  = 15;
  localparam int STEP  = 3;
  localparam int HD    = 8;
  localparam int RP    = 4;

  typedef struct {
    int cycle;
    int value;
    bit changed;
    bit atMin;
    bit atMax;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             keyUp = 1'b1;
  logic             keyDown = 1'b1;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] value;
  logic             changed, atMin, atMax;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleNo = 0;

  // Reference model: tracks how long the active key has been held since its
  // first step, and derives step times from that duration directly.
  int  mValue = INIT;
  bit  mLocked = 1'b1;
  int  mActive = 0;
  int  mHeld = 0;
  bit  mChanged = 1'b0;

  key_stepper #(
    .WIDTH(WIDTH), .MIN(MIN), .MAX(MAX), .INIT(INIT), .STEP(STEP),
    .HOLD_DELAY(HD), .REPEAT_PERIOD(RP)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_key_up(keyUp), .i_key_down(keyDown),
    .i_clear(clear), .o_value(value), .o_changed(changed),
    .o_at_min(atMin), .o_at_max(atMax)
  );

  always #5 clk = ~clk;

  function automatic void modelStep(int dir);
    int nv;
    nv = (dir > 0) ? ((mValue + STEP > MAX) ? MAX : mValue + STEP)
                   : ((mValue - STEP < MIN) ? MIN : mValue - STEP);
    mChanged = (nv != mValue);
    mValue   = nv;
  endfunction

  function automatic void modelEdge(bit up, bit dn, bit clr, bit rst);
    bit actP, othP;
    mChanged = 1'b0;
    if (rst) begin
      mValue = INIT; mLocked = 1'b1; mActive = 0;
    end else if (clr) begin
      mChanged = (mValue != INIT);
      mValue = INIT; mLocked = 1'b1; mActive = 0;
    end else if (mLocked) begin
      if (!up && !dn) mLocked = 1'b0;
    end else if (mActive == 0) begin
      if (up && dn) mLocked = 1'b1;
      else if (up) begin mActive = 1; mHeld = 0; modelStep(1); end
      else if (dn) begin mActive = -1; mHeld = 0; modelStep(-1); end
    end else begin
      actP = (mActive > 0) ? up : dn;
      othP = (mActive > 0) ? dn : up;
      if (!actP) mActive = 0;
      else if (othP) begin mLocked = 1'b1; mActive = 0; end
      else begin
        mHeld++;
        if (mHeld == HD || (mHeld > HD && ((mHeld - HD) % RP) == 0)) modelStep(mActive);
      end
    end
  endfunction

  // Drives one cycle of inputs (keys given as pressed=1) and queues the
  // response expected after the following rising edge.
  task automatic applyStimulus(bit up, bit dn, bit clr, bit rst);
    exp_t e;
    @(negedge clk);
    keyUp   = ~up;
    keyDown = ~dn;
    clear   = clr;
    reset   = rst;
    modelEdge(up, dn, clr, rst);
    cycleNo++;
    e.cycle   = cycleNo;
    e.value   = mValue;
    e.changed = mChanged;
    e.atMin   = (mValue == MIN);
    e.atMax   = (mValue == MAX);
    expQ.push_back(e);
  endtask

  task automatic run(int n, bit up, bit dn, bit clr = 1'b0, bit rst = 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(up, dn, clr, rst);
  endtask

  task automatic checkOutput(exp_t e);
    checks += 4;
    if (int'(value) != e.value) begin
      errors++;
      $display("[TB] FAIL value cycle %0d: got %0d expected %0d", e.cycle, value, e.value);
    end
    if (changed !== e.changed) begin
      errors++;
      $display("[TB] FAIL changed cycle %0d: got %b expected %b", e.cycle, changed, e.changed);
    end
    if (atMin !== e.atMin) begin
      errors++;
      $display("[TB] FAIL at_min cycle %0d: got %b expected %b", e.cycle, atMin, e.atMin);
    end
    if (atMax !== e.atMax) begin
      errors++;
      $display("[TB] FAIL at_max cycle %0d: got %b expected %b", e.cycle, atMax, e.atMax);
    end
  endtask

  // Monitor: the DUT presents a registered result every cycle; pop and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    int kind, len;
    bit clr, rst;

    run(3, 1, 0, 0, 1);
    run(3, 1, 0);
    run(2, 0, 0);
    run(3, 1, 0);
    run(3, 0, 0);
    run(1, 0, 0, 1);
    run(2, 0, 0);
    run(30, 1, 0);
    run(2, 0, 0);
    run(1, 0, 0, 1);
    run(2, 0, 0);
    run(2, 0, 1); run(2, 0, 0);
    run(2, 0, 1); run(2, 0, 0);
    run(2, 0, 1); run(2, 0, 0);
    run(3, 1, 1);
    run(2, 0, 0);
    run(10, 1, 0);
    run(10, 1, 1);
    run(2, 0, 0);
    run(2, 1, 0); run(2, 0, 0);
    run(20, 1, 0);
    run(1, 1, 0, 1);
    run(12, 1, 0);
    run(2, 0, 0);
    run(2, 1, 0); run(2, 0, 0);
    run(10, 1, 0);
    run(1, 1, 0, 0, 1);
    run(12, 1, 0);
    run(2, 0, 0);
    run(2, 1, 0); run(2, 0, 0);

    for (int p = 0; p < 80; p++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 22);
      for (int c = 0; c < len; c++) begin
        clr = ($urandom_range(0, 39) == 0);
        rst = ($urandom_range(0, 199) == 0);
        case (kind)
          0, 1, 2: applyStimulus(1, 0, clr, rst);
          3, 4, 5: applyStimulus(0, 1, clr, rst);
          6:       applyStimulus(1, 1, clr, rst);
          7, 8:    applyStimulus(0, 0, clr, rst);
          default: applyStimulus(1, (c > len / 2), clr, rst);
        endcase
      end
    end

    run(2, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
